// File: rtl/ncl_ctrl_pkg.sv
// Shared types and dual-rail helpers for the clocked NCL adder front-end.
// Pair encoding per bit: {rail1, rail0}; 01 = DATA0, 10 = DATA1, 00 = NULL.
package ncl_ctrl_pkg;

  localparam int NCL_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT_DATA,
    ST_NULLING,
    ST_WAIT_NULL,
    ST_RESP,
    ST_FAULT
  } state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  function automatic logic [2*NCL_W-1:0] dr_encode(input logic [NCL_W-1:0] bin);
    logic [2*NCL_W-1:0] dr;
    dr = '0;
    for (int i = 0; i < NCL_W; i++) begin
      dr[2*i +: 2] = bin[i] ? DR_1 : DR_0;
    end
    return dr;
  endfunction

  // Returns {err, value}; an illegal pair (00 or 11) flags err and decodes to 0.
  function automatic logic [NCL_W:0] dr_decode(input logic [2*NCL_W-1:0] dr);
    logic [NCL_W-1:0] bin;
    logic             err;
    bin = '0;
    err = 1'b0;
    for (int i = 0; i < NCL_W; i++) begin
      case (dr[2*i +: 2])
        DR_1:    bin[i] = 1'b1;
        DR_0:    bin[i] = 1'b0;
        default: err    = 1'b1;
      endcase
    end
    return {err, bin};
  endfunction

endpackage

// File: rtl/ncl_comp_sync.sv
// Multi-flop synchronizer bringing the adder's asynchronous completion into clk.
module ncl_comp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic init,
  input  logic comp_async,
  output logic comp_sync
);

  logic [SYNC_STAGES-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (init) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], comp_async};
    end
  end

  assign comp_sync = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_adder_arbiter.sv
// Round-robin clocked front-end sharing one dual-rail NCL adder between two requesters.
// W must match NCL_W in ncl_ctrl_pkg, which sizes the encode/decode helpers.
module ncl_adder_arbiter
  import ncl_ctrl_pkg::*;
#(
  parameter int W           = NCL_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic           clk,
  input  logic           init,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           ack0,
  output logic           ack1,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic           rsp_err,
  output logic           busy,
  output logic           fault,
  output logic [2*W-1:0] ncl_a,
  output logic [2*W-1:0] ncl_b,
  output logic [1:0]     ncl_cin,
  input  logic [2*W-1:0] ncl_sum,
  input  logic [1:0]     ncl_cout,
  input  logic           ncl_comp
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state_reg, state_next;
  logic             ptr_reg;
  logic             id_reg;
  logic [W-1:0]     op_a_reg, op_b_reg;
  logic [W-1:0]     sum_reg;
  logic             cout_reg, err_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2*W-1:0]   ncl_a_reg, ncl_b_reg;
  logic [1:0]       ncl_cin_reg;
  logic             rsp_valid_reg, ack0_reg, ack1_reg;

  logic             comp_sync;
  logic             grant_id;
  logic             timeout_hit;
  logic             waiting;
  logic [2*W-1:0]   enc_a, enc_b;
  logic [W:0]       dec_word;
  logic             dec_err;
  logic             dec_cout;

  ncl_comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_comp_sync (
    .clk        (clk),
    .init       (init),
    .comp_async (ncl_comp),
    .comp_sync  (comp_sync)
  );

  // ptr_reg names the requester favoured when both are pending.
  assign grant_id    = (req0 && req1) ? ptr_reg : req1;
  assign waiting     = (state_reg == ST_WAIT_DATA) || (state_reg == ST_WAIT_NULL);
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  assign enc_a    = dr_encode(op_a_reg);
  assign enc_b    = dr_encode(op_b_reg);
  assign dec_word = dr_decode(ncl_sum);
  assign dec_cout = (ncl_cout == DR_1);
  assign dec_err  = dec_word[W] || ((ncl_cout != DR_0) && (ncl_cout != DR_1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (req0 || req1) state_next = ST_DRIVE;
      ST_DRIVE:     state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: if (comp_sync || timeout_hit) state_next = ST_NULLING;
      ST_NULLING:   state_next = ST_WAIT_NULL;
      ST_WAIT_NULL: begin
        if (!comp_sync)       state_next = ST_RESP;
        else if (timeout_hit) state_next = ST_FAULT;
      end
      ST_RESP:      state_next = ST_IDLE;
      ST_FAULT:     state_next = ST_FAULT;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      ncl_a_reg     <= '0;
      ncl_b_reg     <= '0;
      ncl_cin_reg   <= DR_NULL;
      rsp_valid_reg <= 1'b0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= (state_reg == ST_RESP);
      ack0_reg      <= (state_reg == ST_RESP) && !id_reg;
      ack1_reg      <= (state_reg == ST_RESP) && id_reg;

      // DATA launches one edge after DRIVE and is held for all of WAIT_DATA,
      // so every rail moves only NULL->DATA or DATA->NULL.
      if (state_reg == ST_WAIT_DATA) begin
        ncl_a_reg   <= enc_a;
        ncl_b_reg   <= enc_b;
        ncl_cin_reg <= DR_0;
      end else begin
        ncl_a_reg   <= '0;
        ncl_b_reg   <= '0;
        ncl_cin_reg <= DR_NULL;
      end

      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (waiting) begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (req0 || req1) begin
            id_reg   <= grant_id;
            op_a_reg <= grant_id ? a1 : a0;
            op_b_reg <= grant_id ? b1 : b0;
          end
        end
        ST_WAIT_DATA: begin
          if (comp_sync) begin
            sum_reg  <= dec_word[W-1:0];
            cout_reg <= dec_cout;
            err_reg  <= dec_err;
          end else if (timeout_hit) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            err_reg  <= 1'b1;
          end
        end
        ST_RESP: ptr_reg <= !id_reg;
        default: ;
      endcase
    end
  end

  assign ack0      = ack0_reg;
  assign ack1      = ack1_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_valid_reg & id_reg;
  assign rsp_sum   = rsp_valid_reg ? sum_reg : '0;
  assign rsp_cout  = rsp_valid_reg & cout_reg;
  assign rsp_err   = rsp_valid_reg & err_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign fault     = (state_reg == ST_FAULT);
  assign ncl_a     = ncl_a_reg;
  assign ncl_b     = ncl_b_reg;
  assign ncl_cin   = ncl_cin_reg;

endmodule

// File: tb/tb_ncl_adder_arbiter.sv
// Scoreboard bench: zero-delay behavioural NCL adder, directed requests, decoupled monitor.
module tb_ncl_adder_arbiter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           init = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, rsp_valid, rsp_id, rsp_cout, rsp_err, busy, fault;
  logic [W-1:0]   rsp_sum;
  logic [2*W-1:0] ncl_a, ncl_b, ncl_sum;
  logic [1:0]     ncl_cin, ncl_cout;
  logic           ncl_comp;

  always #5 clk = ~clk;

  ncl_adder_arbiter dut (
    .clk(clk), .init(init), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .busy(busy), .fault(fault),
    .ncl_a(ncl_a), .ncl_b(ncl_b), .ncl_cin(ncl_cin),
    .ncl_sum(ncl_sum), .ncl_cout(ncl_cout), .ncl_comp(ncl_comp)
  );

  // Behavioural adder: 0 = normal, 1 = completion stuck at 0, 2 = stuck at 1.
  int           model_mode = 0;
  logic         bad_bit5 = 1'b0;
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_s;
  logic         m_data;

  always_comb begin
    m_a = '0;
    m_b = '0;
    for (int i = 0; i < W; i++) begin
      m_a[i] = ncl_a[2*i+1];
      m_b[i] = ncl_b[2*i+1];
    end
    m_s      = {1'b0, m_a} + {1'b0, m_b};
    m_data   = (ncl_cin == 2'b01);
    ncl_sum  = '0;
    ncl_cout = 2'b00;
    if (m_data) begin
      for (int i = 0; i < W; i++) ncl_sum[2*i +: 2] = m_s[i] ? 2'b10 : 2'b01;
      ncl_cout = m_s[W] ? 2'b10 : 2'b01;
      if (bad_bit5) ncl_sum[11:10] = 2'b11;
    end
    ncl_comp = m_data;
    if (model_mode == 1) ncl_comp = 1'b0;
    if (model_mode == 2) ncl_comp = 1'b1;
  end

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per response and times it from the IDLE sample edge.
  initial begin : monitor
    logic busy_d, valid_d;
    int   start_edge;
    exp_t e;
    busy_d = 1'b0;
    valid_d = 1'b0;
    start_edge = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_d) start_edge = edge_cnt;
      busy_d = busy;
      if (valid_d) check("ack_single_cycle", {62'd0, ack1, ack0}, 64'd0);
      valid_d = rsp_valid;
      if (ack0 || ack1 || rsp_valid) check("ack_with_valid", {63'd0, ack0 | ack1}, {63'd0, rsp_valid});
      if (rsp_valid) begin
        $display("[TB] rsp id=%0d sum=0x%08h cout=%0b err=%0b", rsp_id, rsp_sum, rsp_cout, rsp_err);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_rsp: got response id=%0d, expected none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
          check("rsp_sum", {32'd0, rsp_sum}, {32'd0, e.sum});
          check("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          check("ack_id", {62'd0, ack1, ack0}, e.id ? 64'd2 : 64'd1);
          check("ncl_a_null_after", ncl_a, 64'd0);
          if (e.chk_lat) check("latency", 64'(edge_cnt - start_edge), 64'd10);
        end
      end
    end
  end

  task automatic wait_ack(input logic id, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL ack_timeout: no ack%0d within %0d cycles, expected one", id, limit);
    end
  endtask

  task automatic single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] s, input logic c, input logic e, input logic lat);
    exp_q.push_back('{id: id, sum: s, cout: c, err: e, chk_lat: lat});
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    wait_ack(id, 3000);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    check("reset_ncl_a", ncl_a, 64'd0);
    check("reset_ncl_b", ncl_b, 64'd0);
    check("reset_ncl_cin", {62'd0, ncl_cin}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_fault", {63'd0, fault}, 64'd0);
    check("reset_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    check("reset_acks", {62'd0, ack1, ack0}, 64'd0);
    init = 1'b0;
    @(negedge clk);
    check("ncl_a_null_before", ncl_a, 64'd0);

    // Carry out of the top bit.
    single(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Contention with pointer freshly reset toward req0.
    pulse_init();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back('{id: 1'b0, sum: 32'd30, cout: 1'b0, err: 1'b0, chk_lat: 1'b1});
      else            exp_q.push_back('{id: 1'b1, sum: 32'd16, cout: 1'b0, err: 1'b0, chk_lat: 1'b1});
    end
    a0 = 32'd10; b0 = 32'd20; a1 = 32'd7; b1 = 32'd9;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("contention_acks", 64'(n), 64'd4);

    // Rail violation on sum bit 5, then a clean transaction.
    bad_bit5 = 1'b1;
    single(1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1, 1'b1);
    bad_bit5 = 1'b0;
    single(1'b1, 32'd100, 32'd200, 32'd300, 1'b0, 1'b0, 1'b1);

    // Completion stuck low: data timeout yields an error response of zeros.
    model_mode = 1;
    single(1'b0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0);

    // Completion stuck high: null timeout lands in FAULT with no response.
    model_mode = 2;
    a1 = 32'd1; b1 = 32'd1; req1 = 1'b1;
    for (int i = 0; i < 3000 && !fault; i++) @(negedge clk);
    check("fault_set", {63'd0, fault}, 64'd1);
    check("fault_busy", {63'd0, busy}, 64'd1);
    check("fault_ncl_null", ncl_a | ncl_b, 64'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
    end
    check("fault_no_ack", 64'(n), 64'd0);
    check("fault_sticky", {63'd0, fault}, 64'd1);
    req1 = 1'b0;
    model_mode = 0;
    pulse_init();
    check("fault_cleared", {62'd0, fault, busy}, 64'd0);

    // Reset during WAIT_DATA aborts without a response.
    a0 = 32'hDEAD_0000; b0 = 32'h0000_BEEF; req0 = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("mid_data_driven", {62'd0, ncl_cin}, 64'd1);
    init = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("mid_reset_ncl", ncl_a | ncl_b, 64'd0);
    check("mid_reset_cin_busy", {61'd0, ncl_cin, busy}, 64'd0);
    init = 1'b0;
    repeat (20) @(negedge clk);
    single(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
